ahbl_excl_monitor: RTL and testbench
====================================

# ahbl_excl_monitor

Global exclusive-access monitor on an AHB-Lite path, placed directly downstream of the strict-priority N:1 arbiter and directly upstream of a single memory slave. It consumes the arbiter's merged address phase, including `hexcl` and `hmaster`, and keeps one address reservation per master. It forwards transfers to the slave, suppresses failing exclusive writes, and generates `hexokay` back toward the arbiter.

## Interface
- `N_MASTERS`, 2: number of reservation slots; valid `hmaster` IDs are 0..N_MASTERS-1.
- `W_ADDR`, 32: address width.
- `W_DATA`, 32: data width.
- `GRAN_LOG2`, 3: log2 of reservation granule size in bytes; address compare uses `haddr[W_ADDR-1:GRAN_LOG2]`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `src_hready`  in  1  bus HREADY from arbiter.
- `src_haddr`, `src_hwrite`, `src_htrans`, `src_hsize`, `src_hburst`, `src_hprot`, `src_hmastlock`, `src_hwdata`  in  AHBL widths  address/data phase from arbiter.
- `src_hexcl`  in  1  exclusive-transfer flag.
- `src_hmaster`  in  8  master ID.
- `src_hready_resp`  out  1  ready response to arbiter.
- `src_hresp`  out  1  error response to arbiter.
- `src_hrdata`  out  W_DATA  read data to arbiter.
- `src_hexokay`  out  1  exclusive-okay to arbiter.
- `dst_hready`  out  1  HREADY to slave.
- `dst_haddr`, `dst_hwrite`, `dst_htrans`, `dst_hsize`, `dst_hburst`, `dst_hprot`, `dst_hmastlock`, `dst_hwdata`  out  AHBL widths  to slave.
- `dst_hready_resp`  in  1  slave ready.
- `dst_hresp`  in  1  slave error.
- `dst_hrdata`  in  W_DATA  slave read data.

## Operation
- Address phase accepted when `src_hready && src_htrans[1]`.
- All `dst_*` address signals pass through combinationally, except `dst_htrans`. `dst_htrans` is forced to 2'b00 for a failing exclusive write.
- `dst_hready = src_hready`. `dst_hwdata = src_hwdata`. `src_hrdata = dst_hrdata`.
- Reservation table, per master m: `res_valid[m]`, `res_gran[m]`.
- Exclusive write from master m passes iff `m < N_MASTERS`, `res_valid_next[m]` is set, and `res_gran_next[m]` equals the granule of `src_haddr`. Otherwise it fails and is suppressed.
- `res_*_next` is the table after this cycle's data-phase update (bypass), not the registered value.
- Data-phase register, loaded on every `src_hready`:
  - `dph_valid`
  - `dph_excl`
  - `dph_write`
  - `dph_sup` (suppressed)
  - `dph_master`
  - `dph_gran`
- Data phase completes when `dph_valid && src_hready_resp`.
- Table update on completion, with `ok = ~src_hresp`:
  - Exclusive read, ok, valid master: set `res_valid[m]` and load `res_gran[m]`.
  - Exclusive read, error: no change.
  - Non-suppressed write, ok (any master, exclusive or not): clear every slot whose `res_gran` equals `dph_gran`.
  - Any exclusive write (pass, fail, or error): clear `res_valid[m]` of the issuer.
  - Clear-by-write takes precedence over a same-cycle set only for different slots; a slot's own set and clear cannot coincide.
- Exclusive read from invalid master ID: forwarded normally, no reservation, `hexokay = 0`.
- `hexcl` on IDLE/BUSY: ignored.
- Responses:
  - Suppressed data phase: `src_hready_resp = 1`, `src_hresp = 0`, `src_hexokay = 0`. The slave sees IDLE.
  - Otherwise: `src_hready_resp = dst_hready_resp` and `src_hresp = dst_hresp`.
  - `src_hexokay = dph_valid & dph_excl & ~dph_sup & (dph_master < N_MASTERS) & ~dst_hresp`.

## Timing
- Reset: all `res_valid = 0`, `dph_valid = 0`.
- Outputs after reset:
  - `src_hexokay = 0`
  - `src_hresp = dst_hresp` (0 with an idle slave)
  - `src_hready_resp = dst_hready_resp`
- Zero added latency; address and response paths are combinational.
- Table updates are visible to the next accepted address phase via the bypass.
- Wait states: the data-phase register holds while `src_hready = 0`. `dst_htrans` suppression stays stable for the whole held address phase.
- Reset mid-operation discards reservations and any pending data phase.

## Test plan
- Exclusive pass: m0 exclusive read 0x100, then m0 exclusive write 0x100 data 0xA5 -> both `hexokay = 1`, slave stores 0xA5, `res_valid[0] = 0` afterwards.
- Intervening write: m0 exclusive read 0x100; m1 normal write 0x104 (same granule with GRAN_LOG2=3); m0 exclusive write 0x100 -> `dst_htrans = 00`, `hexokay = 0`, `src_hready_resp = 1`, memory keeps m1's data.
- Contention: m0 and m1 both exclusive read 0x200; m1 exclusive write succeeds (`hexokay = 1`); m0 exclusive write 0x200 fails (`hexokay = 0`, suppressed).
- Bypass: m0 reserves 0x300. A normal write to 0x300 completes in the same cycle the m0 exclusive write to 0x300 is accepted -> exclusive write fails.
- No reservation / bad ID: exclusive write with no prior read -> suppressed. Exclusive read with `hmaster = N_MASTERS` -> data returned, `hexokay = 0`.
- Error and reset:
  - Slave error on exclusive read 0x400 -> `hresp = 1`, `hexokay = 0`, following exclusive write fails.
  - Reserve 0x500, assert `rst` one cycle, exclusive write 0x500 -> fails.

Source files
------------

// File: rtl/ahbl_excl_monitor.sv
// ahbl_excl_monitor: global exclusive-access monitor between an AHB-Lite
// arbiter and a single slave. It keeps one address-granule reservation per
// master, suppresses exclusive writes that lost their reservation, and
// reports exclusive-okay back toward the arbiter. The address and response
// paths are combinational, so the monitor adds no latency.
module ahbl_excl_monitor #(
  parameter int N_MASTERS = 2,
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int GRAN_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  // merged address/data phase from the arbiter
  input  logic              src_hready,
  input  logic [W_ADDR-1:0] src_haddr,
  input  logic              src_hwrite,
  input  logic [1:0]        src_htrans,
  input  logic [2:0]        src_hsize,
  input  logic [2:0]        src_hburst,
  input  logic [3:0]        src_hprot,
  input  logic              src_hmastlock,
  input  logic [W_DATA-1:0] src_hwdata,
  input  logic              src_hexcl,
  input  logic [7:0]        src_hmaster,
  output logic              src_hready_resp,
  output logic              src_hresp,
  output logic [W_DATA-1:0] src_hrdata,
  output logic              src_hexokay,
  // toward the slave
  output logic              dst_hready,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [2:0]        dst_hburst,
  output logic [3:0]        dst_hprot,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata,
  input  logic              dst_hready_resp,
  input  logic              dst_hresp,
  input  logic [W_DATA-1:0] dst_hrdata
);

  localparam int         W_GRAN = W_ADDR - GRAN_LOG2;
  localparam logic [7:0] N_M8   = 8'(N_MASTERS);

  // reservation table
  logic [N_MASTERS-1:0] res_valid_q, res_valid_d;
  logic [W_GRAN-1:0]    res_gran_q [N_MASTERS];
  logic [W_GRAN-1:0]    res_gran_d [N_MASTERS];

  // data-phase register
  logic              dph_valid_q, dph_excl_q, dph_write_q, dph_sup_q;
  logic [7:0]        dph_master_q;
  logic [W_GRAN-1:0] dph_gran_q;

  logic              dph_done_s, ok_s, pass_s, sup_s;
  logic [W_GRAN-1:0] addr_gran_s;

  assign addr_gran_s = src_haddr[W_ADDR-1:GRAN_LOG2];

  // Pass-through paths; only htrans is altered, to hide a failing exclusive write.
  assign dst_hready    = src_hready;
  assign dst_haddr     = src_haddr;
  assign dst_hwrite    = src_hwrite;
  assign dst_htrans    = sup_s ? 2'b00 : src_htrans;
  assign dst_hsize     = src_hsize;
  assign dst_hburst    = src_hburst;
  assign dst_hprot     = src_hprot;
  assign dst_hmastlock = src_hmastlock;
  assign dst_hwdata    = src_hwdata;
  assign src_hrdata    = dst_hrdata;

  // Response mux: a suppressed data phase is answered locally with OKAY.
  always_comb begin
    src_hready_resp = dst_hready_resp;
    src_hresp       = dst_hresp;
    if (dph_valid_q && dph_sup_q) begin
      src_hready_resp = 1'b1;
      src_hresp       = 1'b0;
    end else begin
      src_hready_resp = dst_hready_resp;
      src_hresp       = dst_hresp;
    end
  end

  assign dph_done_s  = dph_valid_q & src_hready_resp;
  assign ok_s        = ~src_hresp;
  assign src_hexokay = dph_valid_q & dph_excl_q & ~dph_sup_q &
                       (dph_master_q < N_M8) & ~dst_hresp;

  // Next reservation table after this cycle's data-phase completion.
  always_comb begin
    res_valid_d = res_valid_q;
    for (int i = 0; i < N_MASTERS; i++) begin
      res_gran_d[i] = res_gran_q[i];
    end
    if (dph_done_s) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (dph_excl_q && !dph_write_q && ok_s && (dph_master_q == 8'(i))) begin
          res_valid_d[i] = 1'b1;
          res_gran_d[i]  = dph_gran_q;
        end else if (dph_write_q && !dph_sup_q && ok_s && (res_gran_q[i] == dph_gran_q)) begin
          res_valid_d[i] = 1'b0;
        end else if (dph_write_q && dph_excl_q && (dph_master_q == 8'(i))) begin
          res_valid_d[i] = 1'b0;
        end else begin
          res_valid_d[i] = res_valid_q[i];
        end
      end
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // Exclusive-write pass check against the bypassed (next) table.
  always_comb begin
    pass_s = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (src_hmaster == 8'(i)) begin
        pass_s = res_valid_d[i] && (res_gran_d[i] == addr_gran_s);
      end else begin
        pass_s = pass_s;
      end
    end
    sup_s = src_htrans[1] & src_hexcl & src_hwrite & ~pass_s;
  end

  // Reservation table and data-phase register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q  <= '0;
      dph_valid_q  <= 1'b0;
      dph_excl_q   <= 1'b0;
      dph_write_q  <= 1'b0;
      dph_sup_q    <= 1'b0;
      dph_master_q <= 8'h00;
      dph_gran_q   <= '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        res_gran_q[i] <= '0;
      end
    end else begin
      res_valid_q <= res_valid_d;
      for (int i = 0; i < N_MASTERS; i++) begin
        res_gran_q[i] <= res_gran_d[i];
      end
      if (src_hready) begin
        dph_valid_q  <= src_htrans[1];
        dph_excl_q   <= src_htrans[1] & src_hexcl;
        dph_write_q  <= src_htrans[1] & src_hwrite;
        dph_sup_q    <= sup_s;
        dph_master_q <= src_hmaster;
        dph_gran_q   <= addr_gran_s;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Bench for ahbl_excl_monitor: pipelined directed transfers, a small memory
// slave with optional two-cycle error response, and a scoreboard whose
// monitor pops expected responses as data phases complete.
module tb_ahbl_excl_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_hready;
  logic [31:0] src_haddr;
  logic        src_hwrite;
  logic [1:0]  src_htrans;
  logic [2:0]  src_hsize;
  logic [2:0]  src_hburst;
  logic [3:0]  src_hprot;
  logic        src_hmastlock;
  logic [31:0] src_hwdata;
  logic        src_hexcl;
  logic [7:0]  src_hmaster;
  logic        src_hready_resp, src_hresp, src_hexokay;
  logic [31:0] src_hrdata;
  logic        dst_hready, dst_hwrite, dst_hmastlock;
  logic [31:0] dst_haddr, dst_hwdata;
  logic [1:0]  dst_htrans;
  logic [2:0]  dst_hsize, dst_hburst;
  logic [3:0]  dst_hprot;
  logic        dst_hready_resp, dst_hresp;
  logic [31:0] dst_hrdata;

  always #5 clk = ~clk;

  // the arbiter's HREADY follows the response seen from the monitor
  assign src_hready = src_hready_resp;

  ahbl_excl_monitor dut (
    .clk(clk), .rst(rst),
    .src_hready(src_hready), .src_haddr(src_haddr), .src_hwrite(src_hwrite),
    .src_htrans(src_htrans), .src_hsize(src_hsize), .src_hburst(src_hburst),
    .src_hprot(src_hprot), .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata),
    .src_hexcl(src_hexcl), .src_hmaster(src_hmaster),
    .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_hrdata(src_hrdata), .src_hexokay(src_hexokay),
    .dst_hready(dst_hready), .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite),
    .dst_htrans(dst_htrans), .dst_hsize(dst_hsize), .dst_hburst(dst_hburst),
    .dst_hprot(dst_hprot), .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata),
    .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp), .dst_hrdata(dst_hrdata)
  );

  // ---------------- memory slave model ----------------
  logic [31:0] mem [512];
  logic        s_valid, s_write, s_err;
  logic [8:0]  s_widx;
  logic        s_cnt;
  logic        err_en;
  logic [31:0] err_addr;

  assign dst_hready_resp = !(s_valid && s_err && !s_cnt);
  assign dst_hresp       = s_valid && s_err;
  assign dst_hrdata      = mem[s_widx];

  // slave state: write on data-phase completion, capture new address phase
  always @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_write <= 1'b0;
      s_err   <= 1'b0;
      s_cnt   <= 1'b0;
      s_widx  <= 9'd0;
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
    end else if (dst_hready) begin
      if (s_valid && s_write && !s_err) mem[s_widx] <= dst_hwdata;
      s_valid <= dst_htrans[1];
      s_write <= dst_hwrite;
      s_err   <= err_en && (dst_haddr == err_addr) && dst_htrans[1];
      s_widx  <= dst_haddr[10:2];
      s_cnt   <= 1'b0;
    end else begin
      s_cnt <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        hr;
    logic        ok;
    logic        ck;
    logic [31:0] rd;
  } resp_t;

  resp_t      resp_q [$];
  logic [1:0] addr_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor_loop();
    logic  pend;
    resp_t r;
    logic [1:0] et;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else if (src_hready) begin
        if (pend) begin
          if (resp_q.size() == 0) begin
            chk("resp_queue_underflow", 32'd1, 32'd0);
          end else begin
            r = resp_q.pop_front();
            chk("hresp", {31'b0, src_hresp}, {31'b0, r.hr});
            chk("hexokay", {31'b0, src_hexokay}, {31'b0, r.ok});
            if (r.ck) chk("hrdata", src_hrdata, r.rd);
          end
        end else begin
          chk("idle_hexokay", {31'b0, src_hexokay}, 32'd0);
          chk("idle_hresp", {31'b0, src_hresp}, 32'd0);
        end
        if (src_htrans[1]) begin
          if (addr_q.size() == 0) begin
            chk("addr_queue_underflow", 32'd1, 32'd0);
          end else begin
            et = addr_q.pop_front();
            chk("dst_htrans", {30'b0, dst_htrans}, {30'b0, et});
          end
        end
        pend = src_htrans[1];
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic act, input logic [7:0] m, input logic w, input logic x,
                       input logic [31:0] a, input logic [31:0] d, input logic sup,
                       input logic hr, input logic ok, input logic ck, input logic [31:0] rd);
    int    n;
    logic  rdy;
    resp_t r;
    src_htrans  = act ? 2'b10 : 2'b00;
    src_haddr   = a;
    src_hwrite  = w;
    src_hexcl   = x;
    src_hmaster = m;
    if (act) begin
      r.hr = hr; r.ok = ok; r.ck = ck; r.rd = rd;
      resp_q.push_back(r);
      addr_q.push_back(sup ? 2'b00 : 2'b10);
    end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 16) begin
      @(negedge clk);
      rdy = src_hready;
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL hready_timeout: got 0 expected 1 (t=%0t)", $time);
    end
    @(posedge clk);
    #1;
    src_hwdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask
  task automatic xr(input logic [7:0] m, input logic [31:0] a, input logic ok, input logic [31:0] rd);
    drive(1'b1, m, 1'b0, 1'b1, a, 32'h0, 1'b0, 1'b0, ok, 1'b1, rd);
  endtask
  task automatic xw(input logic [7:0] m, input logic [31:0] a, input logic [31:0] d, input logic sup);
    drive(1'b1, m, 1'b1, 1'b1, a, d, sup, 1'b0, !sup, 1'b0, 32'h0);
  endtask
  task automatic nw(input logic [7:0] m, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, m, 1'b1, 1'b0, a, d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask
  task automatic nr(input logic [7:0] m, input logic [31:0] a, input logic [31:0] rd);
    drive(1'b1, m, 1'b0, 1'b0, a, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, rd);
  endtask

  initial begin
    rst = 1'b1;
    src_haddr = 32'h0; src_hwrite = 1'b0; src_htrans = 2'b00;
    src_hsize = 3'b010; src_hburst = 3'b000; src_hprot = 4'b0011;
    src_hmastlock = 1'b0; src_hwdata = 32'h0; src_hexcl = 1'b0; src_hmaster = 8'd0;
    err_en = 1'b0; err_addr = 32'h0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(); idle();

    // exclusive pass, then a repeat write without reservation fails
    xr(8'd0, 32'h100, 1'b1, 32'h0);
    xw(8'd0, 32'h100, 32'hA5, 1'b0);
    xw(8'd0, 32'h100, 32'h11, 1'b1);
    nr(8'd0, 32'h100, 32'hA5);
    idle();

    // intervening write to the same granule kills the reservation
    xr(8'd0, 32'h100, 1'b1, 32'hA5);
    nw(8'd1, 32'h104, 32'hBEEF);
    xw(8'd0, 32'h100, 32'h22, 1'b1);
    nr(8'd1, 32'h104, 32'hBEEF);
    nr(8'd0, 32'h100, 32'hA5);
    idle();

    // contention: m1 wins, m0 loses
    xr(8'd0, 32'h200, 1'b1, 32'h0);
    xr(8'd1, 32'h200, 1'b1, 32'h0);
    xw(8'd1, 32'h200, 32'h33, 1'b0);
    xw(8'd0, 32'h200, 32'h44, 1'b1);
    nr(8'd0, 32'h200, 32'h33);
    idle();

    // bypass: normal write completes as the exclusive write is accepted
    xr(8'd0, 32'h300, 1'b1, 32'h0);
    nw(8'd1, 32'h300, 32'h55);
    xw(8'd0, 32'h300, 32'h66, 1'b1);
    nr(8'd0, 32'h300, 32'h55);
    idle();

    // no reservation, and an out-of-range master ID
    xw(8'd1, 32'h600, 32'h77, 1'b1);
    xr(8'd2, 32'h300, 1'b0, 32'h55);
    nr(8'd0, 32'h600, 32'h0);
    idle();

    // slave error on exclusive read, following exclusive write fails
    err_en = 1'b1;
    err_addr = 32'h400;
    drive(1'b1, 8'd0, 1'b0, 1'b1, 32'h400, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    xw(8'd0, 32'h400, 32'h88, 1'b1);
    idle();
    err_en = 1'b0;
    nr(8'd0, 32'h400, 32'h0);
    idle();

    // reset drops the reservation
    xr(8'd1, 32'h500, 1'b1, 32'h0);
    idle(); idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    xw(8'd1, 32'h500, 32'h99, 1'b1);
    nr(8'd1, 32'h500, 32'h0);
    idle();

    // positive control after reset
    xr(8'd0, 32'h500, 1'b1, 32'h0);
    xw(8'd0, 32'h500, 32'hAA, 1'b0);
    nr(8'd0, 32'h500, 32'hAA);
    idle(); idle(); idle();

    chk("resp_queue_drained", resp_q.size(), 32'd0);
    chk("addr_queue_drained", addr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
